traffic_ctrl_2dir: RTL and testbench
====================================

# traffic_ctrl_2dir

Parametrised two-approach intersection controller, clocked by the 1 Hz system tick, and the successor to the single-approach light FSM. It drives red/yellow/green for approaches A and B with an all-red clearance interval between them. It provides a per-approach countdown of seconds remaining in the current colour, plus a night flashing-yellow mode. An optional pedestrian-request path shortens a running green.

## Interface
- CNT_W, 8: width of phase counter and countdown outputs
- GREEN_A, 30: A green duration (clocks)
- GREEN_B, 25: B green duration
- YELLOW, 5: yellow duration, both approaches
- ALL_RED, 2: all-red clearance duration
- PED_CUT, 5: remaining green after a pedestrian cut

Ports:
- clock1Hz  in  1  system clock, one edge per second; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- start_dir  in  1  approach given green after reset or after leaving flash (0=A, 1=B)
- night  in  1  level; request flashing-yellow mode
- ped_req  in  1  pedestrian button, sampled each clock
- RA, YA, GA  out  1 each  approach A lamps
- RB, YB, GB  out  1 each  approach B lamps
- NUM_A, NUM_B  out  CNT_W  seconds remaining in the current colour, per approach
- state  out  3  current state code
- ped_ack  out  1  one-clock pulse when a pedestrian cut is applied

## Operation
- States: 0 A_GRN, 1 A_YEL, 2 RED_AB, 3 B_GRN, 4 B_YEL, 5 RED_BA, 6 FLASH.
- Normal cycle: A_GRN → A_YEL → RED_AB → B_GRN → B_YEL → RED_BA → A_GRN.
- Phase counter cnt:
  - Loaded with the new phase's duration on entry.
  - Decrements each clock.
  - At a clock edge with cnt==1, the block moves to the next state and loads that state's duration.
  - Each phase therefore lasts exactly its duration in clocks.
- Lamps, decoded from state:
  - A_GRN: GA, RB.
  - A_YEL: YA, RB.
  - RED_AB and RED_BA: RA, RB.
  - B_GRN: RA, GB.
  - B_YEL: RA, YB.
  - FLASH: YA=YB=flash bit, all R and G low.
- NUM_A by state:
  - A_GRN, A_YEL, RED_BA: cnt.
  - RED_AB: cnt+GREEN_B+YELLOW+ALL_RED.
  - B_GRN: cnt+YELLOW+ALL_RED.
  - B_YEL: cnt+ALL_RED.
  - FLASH: 0.
- NUM_B: symmetric to NUM_A with A/B swapped.
- Sums are modulo 2^CNT_W. Parameters must keep every sum below 2^CNT_W; the block does not check this.
- Night entry:
  - night=1 sampled in a green state: next edge moves to that approach's yellow with cnt=YELLOW.
  - night=1 sampled at the end of a yellow or all-red phase (cnt==1): next state is FLASH instead of the normal successor.
- In FLASH, the flash bit toggles every clock and starts at 1 on entry.
- Night exit: night=0 sampled in FLASH → next state is the all-red preceding start_dir's green (start_dir=0: RED_BA; start_dir=1: RED_AB), with cnt=ALL_RED.
- Priority: reset > night > pedestrian > normal countdown.

## Timing
- Reset (rst=0, asynchronous): state=A_GRN with cnt=GREEN_A if start_dir=0; state=B_GRN with cnt=GREEN_B if start_dir=1. Flash bit=0, ped pending=0, ped_ack=0.
- Reset outputs, start_dir=0: GA=1, RB=1, others 0, NUM_A=30, NUM_B=37.
- Reset mid-phase aborts immediately, with no clearance interval.
- Lamps and NUM are combinational from registered state/cnt, valid in the same cycle as the state change.
- night and ped_req are acted on at the first posedge where they are sampled; there is no synchroniser.

## Configuration
- Macro PED_REQ_EN.
- When defined:
  - ped_req=1 sets a sticky pending flag.
  - While pending in A_GRN or B_GRN with cnt>PED_CUT: next edge loads cnt=PED_CUT, clears pending, and pulses ped_ack for one clock.
  - If cnt≤PED_CUT, no cut is made and no ack is given; pending clears on entry to yellow.
  - A request during yellow or all-red stays pending and applies to the next green.
  - Night mode clears pending.
- When undefined: ped_req is ignored, ped_ack is tied to 0, and the ports remain present.

## Test plan
- start_dir=0, release reset → GA=1, NUM_A=30, NUM_B=37; after 30 clocks state=1, NUM_A=5; the full cycle returns to A_GRN after 69 clocks.
- start_dir=1, release reset → GB=1, NUM_B=25, NUM_A=32; after 25 clocks YB=1.
- night=1 at A_GRN with cnt=20 → next edge A_YEL with NUM_A=5; 5 clocks later FLASH, YA/YB sequence 1,0,1,0; night=0 → RED_BA for 2 clocks, then A_GRN with NUM_A=30.
- PED_REQ_EN, one-clock ped_req at A_GRN with cnt=20 → next edge NUM_A=5 and ped_ack=1 for exactly one clock; A_YEL 5 clocks later. The same request at cnt=4 → no ack and unchanged timing.
- rst=0 asserted mid B_YEL, asynchronously between edges → outputs switch to reset values immediately, without waiting for an edge.
- PED_REQ_EN undefined: ped_req held at 1 for a full cycle → ped_ack stays 0 and cycle length stays 69 clocks.

Source files
------------

// File: rtl/traffic_ctrl_2dir.sv
// Two-approach intersection controller with all-red clearance, per-approach countdowns
// and night flashing-yellow mode. Define PED_REQ_EN to enable the pedestrian green cut.
module traffic_ctrl_2dir #(
    parameter int CNT_W   = 8,
    parameter int GREEN_A = 30,
    parameter int GREEN_B = 25,
    parameter int YELLOW  = 5,
    parameter int ALL_RED = 2,
    parameter int PED_CUT = 5
) (
    input  logic             clock1Hz,
    input  logic             rst,
    input  logic             start_dir,
    input  logic             night,
    input  logic             ped_req,
    output logic             RA,
    output logic             YA,
    output logic             GA,
    output logic             RB,
    output logic             YB,
    output logic             GB,
    output logic [CNT_W-1:0] NUM_A,
    output logic [CNT_W-1:0] NUM_B,
    output logic [2:0]       state,
    output logic             ped_ack
);

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5,
        FLASH  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] T_GA = CNT_W'(GREEN_A);
    localparam logic [CNT_W-1:0] T_GB = CNT_W'(GREEN_B);
    localparam logic [CNT_W-1:0] T_Y  = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALL_RED);
    localparam logic [CNT_W-1:0] T_PC = CNT_W'(PED_CUT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             flash_reg, flash_next;
    logic             ped_pend;
    logic             ped_cut;
    logic             ped_clear;
    logic             last;

    always_ff @(posedge clock1Hz or negedge rst) begin
        if (!rst) begin
            state_reg <= start_dir ? B_GRN : A_GRN;
            cnt_reg   <= start_dir ? T_GB : T_GA;
            flash_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            flash_reg <= flash_next;
        end
    end

    assign last = (cnt_reg == CNT_W'(1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - 1'b1;
        flash_next = flash_reg;
        ped_cut    = 1'b0;
        ped_clear  = night;
        case (state_reg)
            A_GRN, B_GRN: begin
                if (night || last) begin
                    state_next = (state_reg == A_GRN) ? A_YEL : B_YEL;
                    cnt_next   = T_Y;
                    ped_clear  = 1'b1;
                end else if (ped_pend && (cnt_reg > T_PC)) begin
                    cnt_next  = T_PC;
                    ped_cut   = 1'b1;
                    ped_clear = 1'b1;
                end
            end
            A_YEL, RED_AB, B_YEL, RED_BA: begin
                if (last) begin
                    if (night) begin
                        state_next = FLASH;
                        cnt_next   = '0;
                        flash_next = 1'b1;
                    end else begin
                        case (state_reg)
                            A_YEL:   begin state_next = RED_AB; cnt_next = T_AR; end
                            RED_AB:  begin state_next = B_GRN;  cnt_next = T_GB; end
                            B_YEL:   begin state_next = RED_BA; cnt_next = T_AR; end
                            default: begin state_next = A_GRN;  cnt_next = T_GA; end
                        endcase
                    end
                end
            end
            FLASH: begin
                cnt_next   = cnt_reg;
                flash_next = ~flash_reg;
                if (!night) begin
                    // leave through the clearance interval that precedes start_dir's green
                    state_next = start_dir ? RED_AB : RED_BA;
                    cnt_next   = T_AR;
                    flash_next = 1'b0;
                end
            end
            default: begin
                state_next = A_GRN;
                cnt_next   = T_GA;
            end
        endcase
    end

`ifdef PED_REQ_EN
    logic pend_reg;
    logic ack_reg;

    // a request sampled on this edge counts immediately, so a one-clock press can cut at once
    assign ped_pend = pend_reg | ped_req;

    always_ff @(posedge clock1Hz or negedge rst) begin
        if (!rst) begin
            pend_reg <= 1'b0;
            ack_reg  <= 1'b0;
        end else begin
            pend_reg <= ped_clear ? 1'b0 : ped_pend;
            ack_reg  <= ped_cut;
        end
    end

    assign ped_ack = ack_reg;
`else
    logic unused_ped;
    assign unused_ped = ped_req ^ ped_clear ^ ped_cut;
    assign ped_pend   = 1'b0;
    assign ped_ack    = 1'b0;
`endif

    always_comb begin
        {RA, YA, GA, RB, YB, GB} = 6'b000000;
        NUM_A = cnt_reg;
        NUM_B = cnt_reg;
        case (state_reg)
            A_GRN:  begin GA = 1'b1; RB = 1'b1; NUM_B = cnt_reg + T_Y + T_AR; end
            A_YEL:  begin YA = 1'b1; RB = 1'b1; NUM_B = cnt_reg + T_AR; end
            RED_AB: begin RA = 1'b1; RB = 1'b1; NUM_A = cnt_reg + T_GB + T_Y + T_AR; end
            B_GRN:  begin RA = 1'b1; GB = 1'b1; NUM_A = cnt_reg + T_Y + T_AR; end
            B_YEL:  begin RA = 1'b1; YB = 1'b1; NUM_A = cnt_reg + T_AR; end
            RED_BA: begin RA = 1'b1; RB = 1'b1; NUM_B = cnt_reg + T_GA + T_Y + T_AR; end
            default: begin
                YA    = flash_reg;
                YB    = flash_reg;
                NUM_A = '0;
                NUM_B = '0;
            end
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_traffic_ctrl_2dir.sv
// Self-checking bench for traffic_ctrl_2dir: directed steps plus random night/ped/start_dir
// traffic against a timeline model of the 69-second cycle.
module tb_traffic_ctrl_2dir;
    localparam int CNT_W = 8;
    localparam int G_A = 30, G_B = 25, Y_D = 5, AR_D = 2, P_C = 5;
    localparam int CYC = G_A + Y_D + AR_D + G_B + Y_D + AR_D;
`ifdef PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_dir = 1'b0;
    logic night = 1'b0;
    logic ped_req = 1'b0;
    logic RA, YA, GA, RB, YB, GB, ped_ack;
    logic [CNT_W-1:0] NUM_A, NUM_B;
    logic [2:0] state;
    logic [25:0] obs;

    int checks = 0;
    int errors = 0;

    // model: position t on the normal-cycle timeline, or flashing
    int bnd [7];
    int t;
    bit m_flash, m_fb, m_pend, m_ack;

    traffic_ctrl_2dir #(
        .CNT_W(CNT_W), .GREEN_A(G_A), .GREEN_B(G_B), .YELLOW(Y_D), .ALL_RED(AR_D), .PED_CUT(P_C)
    ) dut (
        .clock1Hz(clk), .rst(rst), .start_dir(start_dir), .night(night), .ped_req(ped_req),
        .RA(RA), .YA(YA), .GA(GA), .RB(RB), .YB(YB), .GB(GB),
        .NUM_A(NUM_A), .NUM_B(NUM_B), .state(state), .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    assign obs = {state, RA, YA, GA, RB, YB, GB, NUM_A, NUM_B, ped_ack};

    function automatic int phase_of(input int tt);
        for (int i = 0; i < 6; i++)
            if (tt < bnd[i+1]) return i;
        return 5;
    endfunction

    task automatic model_reset();
        t = start_dir ? bnd[3] : 0;
        m_flash = 0; m_fb = 0; m_pend = 0; m_ack = 0;
    endtask

    task automatic model_step();
        bit pe;
        int p, rem;
        pe = PED_EN && (m_pend || ped_req);
        m_ack = 0;
        if (m_flash) begin
            m_fb = !m_fb;
            if (!night) begin
                m_flash = 0;
                t = start_dir ? bnd[2] : bnd[5];
            end
            m_pend = night ? 1'b0 : pe;
        end else begin
            p = phase_of(t);
            rem = bnd[p+1] - t;
            if (p == 0 || p == 3) begin
                if (night) begin
                    t = bnd[p+1]; m_pend = 0;
                end else if (pe && rem > P_C) begin
                    t = bnd[p+1] - P_C; m_ack = 1; m_pend = 0;
                end else begin
                    t = t + 1; m_pend = (rem == 1) ? 1'b0 : pe;
                end
            end else if (rem == 1 && night) begin
                m_flash = 1; m_fb = 1; m_pend = 0;
            end else begin
                t = (t + 1) % CYC;
                m_pend = night ? 1'b0 : pe;
            end
        end
    endtask

    function automatic logic [25:0] model_vec();
        int p, na, nb;
        logic [2:0] st;
        logic [5:0] lamps;
        if (m_flash) return {3'd6, 1'b0, m_fb, 1'b0, 1'b0, m_fb, 1'b0, 8'd0, 8'd0, m_ack};
        p = phase_of(t);
        st = 3'(p);
        lamps[5:3] = (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
        lamps[2:0] = (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
        // seconds until each approach's colour next changes
        na = (p < 2) ? bnd[p+1] - t : CYC - t;
        nb = (p == 3 || p == 4) ? bnd[p+1] - t : (t < bnd[3] ? bnd[3] - t : CYC - t + bnd[3]);
        return {st, lamps, 8'(na), 8'(nb), m_ack};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic check_model(input string tag);
        chk(tag, 32'(obs), 32'(model_vec()));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_model("cycle");
        end
    endtask

    task automatic async_reset(input logic sd);
        start_dir = sd;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : main
        bit found;
        bnd[0] = 0;
        bnd[1] = G_A;
        bnd[2] = bnd[1] + Y_D;
        bnd[3] = bnd[2] + AR_D;
        bnd[4] = bnd[3] + G_B;
        bnd[5] = bnd[4] + Y_D;
        bnd[6] = bnd[5] + AR_D;

        // reset, start_dir=0
        #1 rst = 1'b0;
        #11;
        chk("reset_vals_a", 32'(obs), 32'({3'd0, 6'b001100, 8'd30, 8'd37, 1'b0}));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(30);
        chk("a_yel_state", 32'(state), 32'd1);
        chk("a_yel_num", 32'(NUM_A), 32'd5);
        tick(39);
        chk("cycle69_state", 32'(state), 32'd0);
        chk("cycle69_num", 32'(NUM_A), 32'd30);

        // night entry from A_GRN at cnt=20, flash, and exit through RED_BA
        tick(10);
        night = 1'b1;
        tick(1);
        chk("night_yel", 32'({state, NUM_A}), 32'({3'd1, 8'd5}));
        tick(5);
        chk("flash_state", 32'(state), 32'd6);
        chk("flash_1", 32'({YA, YB}), 32'b11);
        tick(1);
        chk("flash_0", 32'({YA, YB}), 32'b00);
        tick(1);
        chk("flash_1b", 32'({YA, YB}), 32'b11);
        tick(1);
        chk("flash_0b", 32'({YA, YB}), 32'b00);
        night = 1'b0;
        tick(1);
        chk("exit_red_ba", 32'({state, NUM_A}), 32'({3'd5, 8'd2}));
        tick(2);
        chk("exit_a_grn", 32'({state, NUM_A}), 32'({3'd0, 8'd30}));

        // pedestrian pulse at A_GRN cnt=20
        tick(10);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
`ifdef PED_REQ_EN
        chk("ped_cut", 32'({NUM_A, ped_ack}), 32'({8'd5, 1'b1}));
        tick(1);
        chk("ped_ack_off", 32'(ped_ack), 32'd0);
        tick(4);
        chk("ped_yel", 32'(state), 32'd1);
`else
        chk("ped_ignored", 32'({NUM_A, ped_ack}), 32'({8'd19, 1'b0}));
`endif

        // pedestrian pulse at A_GRN cnt=4: no cut
        found = 0;
        for (int k = 0; k < 120 && !found; k++) begin
            if (!m_flash && t == bnd[1] - 4) found = 1;
            else tick(1);
        end
        chk("wait_cnt4", 32'(found), 32'd1);
        ped_req = 1'b1;
        tick(1);
        ped_req = 1'b0;
        chk("ped_late", 32'({NUM_A, ped_ack}), 32'({8'd3, 1'b0}));
        tick(3);
        chk("ped_late_yel", 32'(state), 32'd1);

        // random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) night = ~night;
            ped_req = ($urandom_range(0, 9) == 0);
            start_dir = 1'($urandom_range(0, 1));
            tick(1);
        end
        night = 1'b0;
        ped_req = 1'b0;

        // asynchronous reset in the middle of B_YEL
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (!m_flash && phase_of(t) == 4 && t != bnd[4]) found = 1;
            else tick(1);
        end
        chk("wait_b_yel", 32'(found), 32'd1);
        start_dir = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_vals_a", 32'(obs), 32'({3'd0, 6'b001100, 8'd30, 8'd37, 1'b0}));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(3);

        // reset with start_dir=1
        async_reset(1'b1);
        chk("reset_vals_b", 32'(obs), 32'({3'd3, 6'b100001, 8'd32, 8'd25, 1'b0}));
        tick(25);
        chk("b_yel", 32'({state, YB}), 32'({3'd4, 1'b1}));

        // ped_req held high for a whole cycle
        async_reset(1'b0);
        ped_req = 1'b1;
        tick(CYC);
        ped_req = 1'b0;
`ifndef PED_REQ_EN
        chk("ped_hold_cycle", 32'({state, NUM_A, ped_ack}), 32'({3'd0, 8'd30, 1'b0}));
`endif
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
